dcache_line_adapter: RTL and testbench
======================================

// Module: dcache_line_adapter
// PURPOSE
//  Sits directly downstream of the dcache datapath, between its 256-bit line port (pmem_*) and the
//  64-bit burst physical-memory bus. Converts one line read into a 4-beat read burst assembled into a
//  256-bit line, and one line write-back into a 4-beat write burst. One transaction in flight at a time.
// PARAMETERS
//  LINE_WIDTH   256  cache line width in bits (matches dcache s_line)
//  BEAT_WIDTH   64   memory bus beat width in bits
//  ADDR_WIDTH   32   byte address width
//  BEATS        LINE_WIDTH/BEAT_WIDTH (=4), localparam; LINE_WIDTH must be an exact multiple
//  OFFSET_BITS  $clog2(LINE_WIDTH/8) (=5), localparam
// PORTS
//  clk           in   1    clock
//  rst           in   1    asynchronous, active-low reset
//  line_read_i   in   1    cache requests line fill (dcache pmem_read)
//  line_write_i  in   1    cache requests line write-back (dcache pmem_write)
//  line_addr_i   in   32   line address (dcache pmem_address)
//  line_wdata_i  in   256  line to write back (dcache pmem_wdata)
//  line_rdata_o  out  256  assembled fill line (dcache pmem_rdata)
//  line_resp_o   out  1    one-cycle completion pulse (dcache mem_resp)
//  burst_read_o  out  1    memory read request, held for the whole burst
//  burst_write_o out  1    memory write request, held for the whole burst
//  burst_addr_o  out  32   line-aligned burst address
//  burst_wdata_o out  64   current write beat
//  burst_rdata_i in   64   current read beat
//  burst_resp_i  in   1    memory beat acknowledge, one pulse per beat
// BEHAVIOUR
//  - Reset (rst low, async): state IDLE, beat counter 0, all outputs 0, line_rdata_o 0, line buffer 0.
//  - States: IDLE, RD_BURST, WR_BURST, DONE.
//  - IDLE: line_write_i=1 -> latch line_addr_i[31:5] and line_wdata_i, go WR_BURST. Else line_read_i=1
//    -> latch address, go RD_BURST. Write has priority if both are high (a simulation assertion flags
//    this as an illegal request). burst_resp_i is ignored in IDLE.
//  - burst_addr_o = {latched_addr[31:OFFSET_BITS], OFFSET_BITS'b0}, stable for the whole transaction.
//  - RD_BURST: burst_read_o=1. Each cycle with burst_resp_i=1, burst_rdata_i is stored to line bits
//    [64k+63:64k], k = beat count (beat 0 first), and the count increments. Beats may be separated by
//    stall cycles with burst_resp_i=0. burst_read_o is still 1 in the cycle of the 4th resp; the next
//    cycle moves to DONE.
//  - WR_BURST: burst_write_o=1; burst_wdata_o = latched line bits [64k+63:64k]. Each burst_resp_i
//    increments k. Completes after 4th resp, next cycle moves to DONE.
//  - DONE: line_resp_o=1 for exactly one cycle. burst_read_o and burst_write_o are 0. Next state is
//    IDLE. line_rdata_o holds the assembled line from DONE until the next RD_BURST starts.
//  - Latency: request accepted at edge 0. With back-to-back beats, line_resp_o is high in cycle 5
//    (1 cycle IDLE->burst, 4 beats, 1 DONE).
//  - The cache deasserts its request on line_resp_o. A request still high in the IDLE cycle after DONE
//    starts a new transaction. This is correct behaviour, not an error.
//  - Inputs line_addr_i and line_wdata_i are don't-care after acceptance; only latched copies drive
//    the bus.
//  - Counter is $clog2(BEATS) bits and wraps to 0 on the last beat. burst_resp_i in DONE is ignored.
//  - Reset mid-burst aborts the burst: outputs drop to 0 asynchronously and no line_resp_o is issued.
// STRUCTURE
//  - cache_pkg (shared): adapter_state_t enum {IDLE, RD_BURST, WR_BURST, DONE}; LINE_WIDTH,
//    BEAT_WIDTH, OFFSET_BITS constants; the same constants are reused by dcache_datapath.
//  - Single flat module. Contents: state register, beat counter, 256-bit line buffer shared by read
//    assembly and write serialisation, address latch. No sub-module.
// TESTING
//  1. Read, no stalls. Request addr 0x0000_1234. Memory returns beats 0x11..11, 0x22..22, 0x33..33,
//     0x44..44 on consecutive cycles. Expected: burst_addr_o=0x0000_1220, line_resp_o pulses once, and
//     line_rdata_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
//  2. Write with stalls. Line = 0xDEADBEEF repeated, addr 0x8000_00E0. Random 0-3 idle cycles between
//     beats. Expected: burst_wdata_o matches each 64-bit slice in order, burst_write_o holds steady,
//     and exactly one line_resp_o follows the 4th beat.
//  3. Simultaneous line_read_i and line_write_i. Expected: a write burst runs, burst_read_o never
//     rises, and the assertion fires.
//  4. Reset low during beat 2 of a read. Expected: outputs are 0 immediately and there is no
//     line_resp_o. A new read after reset completes correctly with fresh data.
//  5. Write-back then fill. Write to 0x0000_0400, then the cache holds line_read_i high for 0x0000_0800
//     immediately after the write's resp. Expected: two separate bursts, burst_addr_o changes only
//     at the IDLE->RD_BURST edge.
//  6. Spurious burst_resp_i in IDLE and DONE. Expected: no state change and no counter change.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache constants and line adapter state type
package cache_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adapter_state_t;

endpackage

// File: rtl/dcache_line_adapter.sv
// rtl/dcache_line_adapter.sv - 256-bit cache line port to 64-bit 4-beat burst memory bus
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   line_read_i/line_write_i cache fill / write-back request (write wins if both)
//   line_addr_i, line_wdata_i request address and write-back line, latched on acceptance
//   line_rdata_o             assembled fill line, valid from DONE onward
//   line_resp_o              one-cycle completion pulse
//   burst_read_o/_write_o    memory request, held for the whole burst
//   burst_addr_o             line-aligned burst address
//   burst_wdata_o            current write beat
//   burst_rdata_i            current read beat
//   burst_resp_i             memory beat acknowledge, one pulse per beat
module dcache_line_adapter
    import cache_pkg::*;
#(
    parameter int LINE_WIDTH = cache_pkg::LINE_WIDTH,
    parameter int BEAT_WIDTH = cache_pkg::BEAT_WIDTH,
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_read_i,
    input  logic                  line_write_i,
    input  logic [ADDR_WIDTH-1:0] line_addr_i,
    input  logic [LINE_WIDTH-1:0] line_wdata_i,
    output logic [LINE_WIDTH-1:0] line_rdata_o,
    output logic                  line_resp_o,
    output logic                  burst_read_o,
    output logic                  burst_write_o,
    output logic [ADDR_WIDTH-1:0] burst_addr_o,
    output logic [BEAT_WIDTH-1:0] burst_wdata_o,
    input  logic [BEAT_WIDTH-1:0] burst_rdata_i,
    input  logic                  burst_resp_i
);

    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_BITS    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS;

    adapter_state_t        state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [LINE_WIDTH-1:0] buf_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic [TAG_BITS-1:0]   addr_q;
    logic [LINE_WIDTH-1:0] assembled;
    logic                  last_beat;

    // Offset bits of the request address never reach the bus.
    logic unused_offset_bits;
    assign unused_offset_bits = ^line_addr_i[OFFSET_BITS-1:0];

    assign last_beat = burst_resp_i && (cnt_q == CNT_BITS'(BEATS - 1));

    // Line buffer with the current read beat merged in; the last beat's
    // result is published straight to line_rdata_o so it is valid in DONE.
    always_comb begin
        assembled = buf_q;
        assembled[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata_i;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (line_write_i) begin
                    state_d = WR_BURST;
                end else if (line_read_i) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST: if (last_beat) state_d = DONE;
            WR_BURST: if (last_beat) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        burst_read_o  = 1'b0;
        burst_write_o = 1'b0;
        line_resp_o   = 1'b0;
        burst_wdata_o = '0;
        case (state_q)
            RD_BURST: burst_read_o = 1'b1;
            WR_BURST: begin
                burst_write_o = 1'b1;
                burst_wdata_o = buf_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH];
            end
            DONE:     line_resp_o = 1'b1;
            default:  ;
        endcase
    end

    assign burst_addr_o = {addr_q, {OFFSET_BITS{1'b0}}};
    assign line_rdata_o = rdata_q;

    // Datapath: address latch, shared line buffer, beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (line_write_i) begin
                        addr_q <= line_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
                        buf_q  <= line_wdata_i;
                    end else if (line_read_i) begin
                        addr_q <= line_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
                    end
                end
                RD_BURST: begin
                    if (burst_resp_i) begin
                        buf_q <= assembled;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            rdata_q <= assembled;
                        end
                    end
                end
                WR_BURST: begin
                    if (burst_resp_i) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Both requests at once is a cache bug; the write is serviced anyway.
    always @(posedge clk) begin
        if (rst && state_q == IDLE) begin
            assert (!(line_read_i && line_write_i))
            else $warning("dcache_line_adapter: line_read_i and line_write_i both high, servicing write");
        end
    end

endmodule

// File: tb/tb_dcache_line_adapter.sv
// tb/tb_dcache_line_adapter.sv - directed and randomized bench for dcache_line_adapter
module tb_dcache_line_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         line_read_i = 1'b0;
    logic         line_write_i = 1'b0;
    logic [31:0]  line_addr_i = '0;
    logic [255:0] line_wdata_i = '0;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic [31:0]  burst_addr_o;
    logic [63:0]  burst_wdata_o;
    logic [63:0]  burst_rdata_i = '0;
    logic         burst_resp_i = 1'b0;

    int errors = 0;
    int checks = 0;

    dcache_line_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .line_read_i  (line_read_i),
        .line_write_i (line_write_i),
        .line_addr_i  (line_addr_i),
        .line_wdata_i (line_wdata_i),
        .line_rdata_o (line_rdata_o),
        .line_resp_o  (line_resp_o),
        .burst_read_o (burst_read_o),
        .burst_write_o(burst_write_o),
        .burst_addr_o (burst_addr_o),
        .burst_wdata_o(burst_wdata_o),
        .burst_rdata_i(burst_rdata_i),
        .burst_resp_i (burst_resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Read transaction: starts mid-IDLE, ends mid-IDLE after DONE.
    task automatic read_txn(input logic [31:0] addr, input logic [63:0] beats [4],
                            input int max_stall, input bit spurious_done);
        logic [255:0] model;
        model = '0;
        for (int k = 0; k < 4; k++) model = model | ({192'b0, beats[k]} << (64 * k));
        line_read_i = 1'b1;
        line_addr_i = addr;
        @(posedge clk); #1;
        line_addr_i = $urandom;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(max_stall, 0);
            for (int s = 0; s < n; s++) begin
                burst_resp_i  = 1'b0;
                burst_rdata_i = rand64();
                @(negedge clk);
                chk("rd_stall_read", burst_read_o, 1'b1);
                chk("rd_stall_resp", line_resp_o, 1'b0);
                @(posedge clk); #1;
            end
            burst_resp_i  = 1'b1;
            burst_rdata_i = beats[k];
            @(negedge clk);
            chk("rd_beat_read", burst_read_o, 1'b1);
            chk("rd_beat_write", burst_write_o, 1'b0);
            chk("rd_beat_addr", burst_addr_o, align(addr));
            @(posedge clk); #1;
        end
        burst_resp_i  = spurious_done;
        burst_rdata_i = rand64();
        @(negedge clk);
        chk("rd_done_resp", line_resp_o, 1'b1);
        chk("rd_done_read", burst_read_o, 1'b0);
        chk("rd_done_line", line_rdata_o, model);
        line_read_i = 1'b0;
        @(posedge clk); #1;
        burst_resp_i = 1'b0;
        @(negedge clk);
        chk("rd_idle_resp", line_resp_o, 1'b0);
        chk("rd_idle_read", burst_read_o, 1'b0);
        chk("rd_idle_line", line_rdata_o, model);
    endtask

    // Write transaction; optionally raises a read for follow_addr during DONE.
    task automatic write_txn(input logic [31:0] addr, input logic [255:0] line, input int max_stall,
                             input bit both, input bit follow_read, input logic [31:0] follow_addr);
        line_write_i = 1'b1;
        line_read_i  = both;
        line_wdata_i = line;
        line_addr_i  = addr;
        @(posedge clk); #1;
        line_wdata_i = rand256();
        line_addr_i  = $urandom;
        for (int k = 0; k < 4; k++) begin
            int n;
            logic [63:0] slice;
            slice = 64'(line >> (64 * k));
            n = $urandom_range(max_stall, 0);
            for (int s = 0; s < n; s++) begin
                burst_resp_i = 1'b0;
                @(negedge clk);
                chk("wr_stall_write", burst_write_o, 1'b1);
                chk("wr_stall_read", burst_read_o, 1'b0);
                chk("wr_stall_wdata", burst_wdata_o, slice);
                @(posedge clk); #1;
            end
            burst_resp_i = 1'b1;
            @(negedge clk);
            chk("wr_beat_write", burst_write_o, 1'b1);
            chk("wr_beat_read", burst_read_o, 1'b0);
            chk("wr_beat_wdata", burst_wdata_o, slice);
            chk("wr_beat_addr", burst_addr_o, align(addr));
            @(posedge clk); #1;
        end
        burst_resp_i = 1'b0;
        @(negedge clk);
        chk("wr_done_resp", line_resp_o, 1'b1);
        chk("wr_done_write", burst_write_o, 1'b0);
        chk("wr_done_read", burst_read_o, 1'b0);
        line_write_i = 1'b0;
        line_read_i  = follow_read;
        line_addr_i  = follow_addr;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_idle_resp", line_resp_o, 1'b0);
        chk("wr_idle_write", burst_write_o, 1'b0);
        chk("wr_idle_read", burst_read_o, 1'b0);
        chk("wr_idle_addr", burst_addr_o, align(addr));
    endtask

    initial begin
        logic [63:0] beats [4];
        logic [255:0] line;

        // Reset state
        #2;
        chk("rst_read", burst_read_o, 1'b0);
        chk("rst_write", burst_write_o, 1'b0);
        chk("rst_resp", line_resp_o, 1'b0);
        chk("rst_addr", burst_addr_o, 32'h0);
        chk("rst_wdata", burst_wdata_o, 64'h0);
        chk("rst_line", line_rdata_o, 256'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1. Read with back-to-back beats
        beats[0] = {16{4'h1}};
        beats[1] = {16{4'h2}};
        beats[2] = {16{4'h3}};
        beats[3] = {16{4'h4}};
        read_txn(32'h0000_1234, beats, 0, 1'b0);
        chk("t1_line", line_rdata_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        chk("t1_addr", burst_addr_o, 32'h0000_1220);

        // 2. Write with stalls
        write_txn(32'h8000_00E0, {8{32'hDEAD_BEEF}}, 3, 1'b0, 1'b0, 32'h0);

        // 3. Simultaneous read and write requests: write must win
        line = rand256();
        write_txn(32'h0000_3300, line, 2, 1'b1, 1'b0, 32'h0);

        // 4. Reset during beat 2 of a read
        line_read_i = 1'b1;
        line_addr_i = 32'h0000_2000;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            burst_resp_i  = 1'b1;
            burst_rdata_i = rand64();
            @(posedge clk); #1;
        end
        burst_resp_i  = 1'b1;
        burst_rdata_i = rand64();
        rst = 1'b0;
        #1;
        chk("t4_read", burst_read_o, 1'b0);
        chk("t4_write", burst_write_o, 1'b0);
        chk("t4_resp", line_resp_o, 1'b0);
        chk("t4_addr", burst_addr_o, 32'h0);
        chk("t4_line", line_rdata_o, 256'h0);
        line_read_i  = 1'b0;
        burst_resp_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_no_resp", line_resp_o, 1'b0);
            chk("t4_no_read", burst_read_o, 1'b0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) beats[k] = rand64();
        read_txn(32'h0000_2008, beats, 2, 1'b0);

        // 5. Write-back then fill requested during the write's DONE
        write_txn(32'h0000_0400, rand256(), 1, 1'b0, 1'b1, 32'h0000_0800);
        for (int k = 0; k < 4; k++) beats[k] = rand64();
        read_txn(32'h0000_0800, beats, 1, 1'b0);

        // 6. Spurious burst_resp_i in IDLE and DONE
        for (int c = 0; c < 3; c++) begin
            burst_resp_i  = 1'b1;
            burst_rdata_i = rand64();
            @(negedge clk);
            chk("t6_idle_read", burst_read_o, 1'b0);
            chk("t6_idle_write", burst_write_o, 1'b0);
            chk("t6_idle_resp", line_resp_o, 1'b0);
            @(posedge clk); #1;
        end
        burst_resp_i = 1'b0;
        for (int k = 0; k < 4; k++) beats[k] = rand64();
        read_txn(32'h0000_5040, beats, 0, 1'b1);
        write_txn(32'h0000_6060, rand256(), 0, 1'b0, 1'b0, 32'h0);

        // Randomized mix
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                write_txn($urandom, rand256(), 3, 1'b0, 1'b0, 32'h0);
            end else begin
                for (int k = 0; k < 4; k++) beats[k] = rand64();
                read_txn($urandom, beats, 3, 1'(i % 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
